// File: rtl/fir_pkg.sv
// Shared types for the 4-tap FIR sequencer: ALU opcodes, register map, FSM states.
package fir_pkg;

    localparam int FIR_REG_ADDR_W = 4;
    localparam int FIR_OP_W       = 3;

    typedef enum logic [FIR_OP_W-1:0] {
        OP_NOP   = 3'd0,
        OP_COPY  = 3'd1,
        OP_LOAD1 = 3'd2,
        OP_LOAD2 = 3'd3,
        OP_ADD   = 3'd4,
        OP_SUB   = 3'd5,
        OP_MUL   = 3'd6
    } op_t;

    typedef logic [FIR_REG_ADDR_W-1:0] reg_idx_t;

    localparam reg_idx_t R_ACC = 4'd0;
    localparam reg_idx_t R_S1  = 4'd1;
    localparam reg_idx_t R_S2  = 4'd2;
    localparam reg_idx_t R_S3  = 4'd3;
    localparam reg_idx_t R_S4  = 4'd4;
    localparam reg_idx_t R_NEW = 4'd5;
    localparam reg_idx_t R_F0  = 4'd6;
    localparam reg_idx_t R_F1  = 4'd7;
    localparam reg_idx_t R_F2  = 4'd8;
    localparam reg_idx_t R_F3  = 4'd9;
    localparam reg_idx_t R_TMP = 4'd10;

    typedef enum logic [4:0] {
        IDLE, STORE, ZERO,
        SORT1, SORT2, SORT3, SORT4,
        MUL1, ADD1, MUL2, SUB2, MUL3, ADD3, MUL4, SUB4,
        EIDLE,
        LOADC0, LOADC1, LOADC2, LOADC3,
        WAITC0, WAITC1, WAITC2
    } state_t;

    typedef struct packed {
        op_t      op;
        reg_idx_t src1;
        reg_idx_t src2;
        reg_idx_t dest;
    } alu_cmd_t;

    function automatic alu_cmd_t alu_cmd(op_t o, reg_idx_t a, reg_idx_t b, reg_idx_t d);
        alu_cmd_t c;
        c.op   = o;
        c.src1 = a;
        c.src2 = b;
        c.dest = d;
        return c;
    endfunction

endpackage

// File: rtl/fir_controller.sv
// Moore sequencer for the 4-tap FIR datapath: sample MAC program and coefficient loading.
// Build option: FIR_OVF_CHECK_EN makes ALU overflow during accumulation abort to EIDLE.
module fir_controller
    import fir_pkg::*;
#(
    parameter int REG_ADDR_W = FIR_REG_ADDR_W,
    parameter int OP_W       = FIR_OP_W
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  dr,
    input  logic                  lc,
    input  logic                  overflow,
    output logic                  cnt_up,
    output logic                  clear,
    output logic                  modwait,
    output logic [OP_W-1:0]       op,
    output logic [REG_ADDR_W-1:0] src1,
    output logic [REG_ADDR_W-1:0] src2,
    output logic [REG_ADDR_W-1:0] dest,
    output logic                  err
);

    state_t   state;
    state_t   next_state;
    alu_cmd_t cmd;
    logic     ovf_abort;

`ifdef FIR_OVF_CHECK_EN
    assign ovf_abort = overflow;
`else
    logic unused_overflow;
    assign unused_overflow = overflow;
    assign ovf_abort       = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Outputs depend on state only; inputs steer next_state alone.
    always_comb begin
        next_state = state;
        cmd        = alu_cmd(OP_NOP, R_ACC, R_ACC, R_ACC);
        cnt_up     = 1'b0;
        clear      = 1'b0;
        modwait    = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                if (dr) begin
                    next_state = STORE;
                end else if (lc) begin
                    next_state = LOADC0;
                end
            end
            STORE: begin
                modwait    = 1'b1;
                cmd        = alu_cmd(OP_LOAD1, R_ACC, R_ACC, R_NEW);
                next_state = dr ? ZERO : EIDLE;
            end
            ZERO: begin
                modwait    = 1'b1;
                cnt_up     = 1'b1;
                cmd        = alu_cmd(OP_SUB, R_ACC, R_ACC, R_ACC);
                next_state = SORT1;
            end
            SORT1: begin
                modwait    = 1'b1;
                cmd        = alu_cmd(OP_COPY, R_S2, R_ACC, R_S1);
                next_state = SORT2;
            end
            SORT2: begin
                modwait    = 1'b1;
                cmd        = alu_cmd(OP_COPY, R_S3, R_ACC, R_S2);
                next_state = SORT3;
            end
            SORT3: begin
                modwait    = 1'b1;
                cmd        = alu_cmd(OP_COPY, R_S4, R_ACC, R_S3);
                next_state = SORT4;
            end
            SORT4: begin
                modwait    = 1'b1;
                cmd        = alu_cmd(OP_COPY, R_NEW, R_ACC, R_S4);
                next_state = MUL1;
            end
            MUL1: begin
                modwait    = 1'b1;
                cmd        = alu_cmd(OP_MUL, R_S1, R_F0, R_TMP);
                next_state = ADD1;
            end
            ADD1: begin
                modwait    = 1'b1;
                cmd        = alu_cmd(OP_ADD, R_ACC, R_TMP, R_ACC);
                next_state = ovf_abort ? EIDLE : MUL2;
            end
            MUL2: begin
                modwait    = 1'b1;
                cmd        = alu_cmd(OP_MUL, R_S2, R_F1, R_TMP);
                next_state = SUB2;
            end
            SUB2: begin
                modwait    = 1'b1;
                cmd        = alu_cmd(OP_SUB, R_ACC, R_TMP, R_ACC);
                next_state = ovf_abort ? EIDLE : MUL3;
            end
            MUL3: begin
                modwait    = 1'b1;
                cmd        = alu_cmd(OP_MUL, R_S3, R_F2, R_TMP);
                next_state = ADD3;
            end
            ADD3: begin
                modwait    = 1'b1;
                cmd        = alu_cmd(OP_ADD, R_ACC, R_TMP, R_ACC);
                next_state = ovf_abort ? EIDLE : MUL4;
            end
            MUL4: begin
                modwait    = 1'b1;
                cmd        = alu_cmd(OP_MUL, R_S4, R_F3, R_TMP);
                next_state = SUB4;
            end
            SUB4: begin
                modwait    = 1'b1;
                cmd        = alu_cmd(OP_SUB, R_ACC, R_TMP, R_ACC);
                next_state = ovf_abort ? EIDLE : IDLE;
            end
            EIDLE: begin
                err = 1'b1;
                if (dr) begin
                    next_state = STORE;
                end
            end
            // Only the first coefficient load restarts the sample counter.
            LOADC0: begin
                modwait    = 1'b1;
                clear      = 1'b1;
                cmd        = alu_cmd(OP_LOAD2, R_ACC, R_ACC, R_F0);
                next_state = WAITC0;
            end
            WAITC0: begin
                if (lc) begin
                    next_state = LOADC1;
                end
            end
            LOADC1: begin
                modwait    = 1'b1;
                cmd        = alu_cmd(OP_LOAD2, R_ACC, R_ACC, R_F1);
                next_state = WAITC1;
            end
            WAITC1: begin
                if (lc) begin
                    next_state = LOADC2;
                end
            end
            LOADC2: begin
                modwait    = 1'b1;
                cmd        = alu_cmd(OP_LOAD2, R_ACC, R_ACC, R_F2);
                next_state = WAITC2;
            end
            WAITC2: begin
                if (lc) begin
                    next_state = LOADC3;
                end
            end
            LOADC3: begin
                modwait    = 1'b1;
                cmd        = alu_cmd(OP_LOAD2, R_ACC, R_ACC, R_F3);
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign op   = OP_W'(cmd.op);
    assign src1 = REG_ADDR_W'(cmd.src1);
    assign src2 = REG_ADDR_W'(cmd.src2);
    assign dest = REG_ADDR_W'(cmd.dest);

endmodule
